ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Shares the single data RAM between two requesters: the core load/store path (port C) and a loader/DMA path (port D) that fills or inspects data memory. It grants at most one access per cycle, issues the RAM control strobes, and routes registered read data back to the winner. It also drives a stall to the core while the core's request is not granted. It sits between the core's ALU/register-file datapath and the RAM instance.

## Interface
- ADDR_W, 12, RAM word address width
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive locked D grants (range 1..15)
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- c_req / d_req  in  1  access request, port C / D
- c_we / d_we  in  1  1 = store, 0 = load
- c_addr / d_addr  in  ADDR_W  word address
- c_wdata / d_wdata  in  DATA_W  store data
- d_lock  in  1  D asks to keep the grant for back-to-back beats
- c_gnt / d_gnt  out  1  access accepted this cycle (combinational)
- c_rvalid / d_rvalid  out  1  read data valid (registered)
- c_rdata / d_rdata  out  DATA_W  read data, valid only with rvalid
- core_stall  out  1  c_req & ~c_gnt
- ram_addr  out  ADDR_W  address of the granted access
- ram_wdata  out  DATA_W  store data of the granted access
- ram_store / ram_load  out  1  RAM write / read strobe
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_load

## Operation
- State: last-winner bit `last` (C=0, D=1), burst counter `bcnt` (4 bits), lock flag `locked`, and read-return register `rd_pend` with `rd_port`.
- Grant decision each cycle, combinational:
  - If `locked` and d_req: D wins.
  - Else if only one port requests: that port wins.
  - Else if both request: the port not equal to `last` wins (round-robin).
- Granted access: ram_addr/ram_wdata are the winner's; ram_store = winner_we; ram_load = ~winner_we. With no grant, ram_store = ram_load = 0 and ram_addr/ram_wdata = 0.
- `last` updates to the winner on every granted cycle and holds otherwise.
- Lock:
  - A D grant with d_lock=1 while not `locked` sets `locked` and sets `bcnt` = 1.
  - Each further locked D grant increments `bcnt`.
  - `locked` clears when any of these holds: d_lock=0 on a D grant, d_req=0, or a grant brings `bcnt` to MAX_BURST.
  - After a lock clears with c_req pending, C is granted on the next contending cycle (`last`=D).
- Read return: a granted load sets `rd_pend`=1 and `rd_port`=winner. Next cycle, rvalid pulses on that port and its rdata = ram_rdata. The other port's rdata is 0.
- Back-to-back loads produce back-to-back rvalid pulses.
- A store and the other port's rvalid may coincide.
- Reads and writes to the same address in consecutive cycles follow RAM ordering. The arbiter does not reorder or forward.

## Timing
- Grant latency: 0 cycles (same cycle as req); read data latency: 1 cycle after grant.
- Requests must be held stable until granted; withdrawing an ungranted request is legal and has no effect.
- Reset (rst=1 at an edge): `last`=D, `locked`=0, `bcnt`=0, `rd_pend`=0.
- While rst=1, all grants, strobes, rvalid and core_stall are forced to 0; ram_addr, ram_wdata and rdata outputs are 0.
- Reset mid-burst or with a read pending: the lock is dropped and the pending rvalid is discarded.
- First contended cycle after reset goes to C.
- With MAX_BURST=1, lock never holds beyond a single beat.
- Worst-case C wait under contention: MAX_BURST cycles.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: round-robin contention resolution as above.
- RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, C always beats D on contention. `locked` still overrides C for at most MAX_BURST beats. `last` is still maintained but is unused.

## Test plan
- Reset: rst=1 for 2 cycles with c_req=d_req=1 -> all grants, strobes, rvalid and core_stall are 0; first cycle after release grants C.
- Single read: C load at addr 0x010, RAM holds 0xDEADBEEF -> c_gnt the same cycle, ram_load=1, ram_addr=0x010; next cycle c_rvalid=1, c_rdata=0xDEADBEEF, d_rvalid=0.
- Contention (round-robin build): c_req and d_req held for 4 cycles -> grants C, D, C, D; core_stall=1 on the D cycles.
- Locked burst, MAX_BURST=4: D stores with d_lock=1 to 0x100..0x105 while c_req=1 -> D wins 4 cycles, C wins cycle 5, D resumes in cycle 6; core_stall=1 for exactly cycles 1-4.
- Fixed priority build (macro undefined): both ports request for 3 cycles with no lock -> C granted all 3 cycles, d_gnt=0.
- Reset mid-operation: assert rst in the cycle after a granted D load with d_lock=1 -> d_rvalid stays 0, `locked` is cleared, and the first cycle after release grants C.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus between the two RAM requesters (core port C, loader port D), the RAM
// instance and the arbiter. The arbiter takes the slave view; requesters and RAM take master.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              core_stall;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_store;
    logic              ram_load;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        input  ram_rdata,
        output c_gnt, c_rvalid, c_rdata, core_stall,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_wdata, ram_store, ram_load
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        output ram_rdata,
        input  c_gnt, c_rvalid, c_rdata, core_stall,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_wdata, ram_store, ram_load
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-RAM arbiter for core port C and loader port D with D burst locking.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise C has fixed priority.
module ram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    port_e       last_q, last_d;
    logic        locked_q, locked_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic        rd_pend_q, rd_pend_d;
    port_e       rd_port_q, rd_port_d;

    logic              c_win, d_win, any_win, win_we;
    logic [3:0]        bcnt_nxt;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (!rst) begin
            if (locked_q && bus.d_req) begin
                d_win = 1'b1;
            end else if (bus.c_req && !bus.d_req) begin
                c_win = 1'b1;
            end else if (bus.d_req && !bus.c_req) begin
                d_win = 1'b1;
            end else if (bus.c_req && bus.d_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                if (last_q == PORT_D) c_win = 1'b1;
                else                  d_win = 1'b1;
`else
                c_win = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        any_win   = c_win | d_win;
        win_we    = d_win ? bus.d_we : bus.c_we;
        win_addr  = '0;
        win_wdata = '0;
        if (c_win) begin
            win_addr  = bus.c_addr;
            win_wdata = bus.c_wdata;
        end else if (d_win) begin
            win_addr  = bus.d_addr;
            win_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        last_d    = last_q;
        locked_d  = locked_q;
        bcnt_d    = bcnt_q;
        bcnt_nxt  = locked_q ? bcnt_q + 4'd1 : 4'd1;
        rd_pend_d = any_win & ~win_we;
        rd_port_d = rd_port_q;

        if (c_win) last_d = PORT_C;
        if (d_win) last_d = PORT_D;
        if (any_win && !win_we) rd_port_d = d_win ? PORT_D : PORT_C;

        // Reaching MAX_BURST on the beat that opens the lock (MAX_BURST=1) never holds it.
        if (d_win && bus.d_lock) begin
            bcnt_d   = bcnt_nxt;
            locked_d = (bcnt_nxt != MAX_B);
        end else if (d_win || !bus.d_req) begin
            locked_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= PORT_D;
            locked_q  <= 1'b0;
            bcnt_q    <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_port_q <= PORT_C;
        end else begin
            last_q    <= last_d;
            locked_q  <= locked_d;
            bcnt_q    <= bcnt_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    assign bus.c_gnt      = c_win;
    assign bus.d_gnt      = d_win;
    assign bus.core_stall = bus.c_req & ~c_win & ~rst;
    assign bus.ram_addr   = win_addr;
    assign bus.ram_wdata  = win_wdata;
    assign bus.ram_store  = any_win & win_we;
    assign bus.ram_load   = any_win & ~win_we;

    assign bus.c_rvalid = rd_pend_q & ~rst & (rd_port_q == PORT_C);
    assign bus.d_rvalid = rd_pend_q & ~rst & (rd_port_q == PORT_D);
    assign bus.c_rdata  = bus.c_rvalid ? bus.ram_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.ram_rdata : '0;
endmodule
